counter_run_controller: RTL

Control stage that sequences one counting run of the counter datapath. It sits directly upstream of that datapath: it accepts a `start`/`ack` handshake from the AXI register block, drives the datapath's `en` and `clear`, and consumes its `done` status. It also exposes busy/ready status, a completion interrupt pulse, a saturating run tally and a watchdog error for the software side.

---
 rtl/counter_run_controller_pkg.sv | 15 +
 rtl/counter_run_controller_watchdog.sv | 30 +++
 rtl/counter_run_controller.sv | 98 +++++++++
 3 files changed

// File: rtl/counter_run_controller_pkg.sv
// Shared definitions for the counter run controller: FSM state encoding
// and default tally width.
package counter_run_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_COUNT    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    localparam int RUN_W_DEFAULT = 8;

endpackage

// File: rtl/counter_run_controller_watchdog.sv
// Watchdog for the COUNT phase: reloads to zero, counts up on request and
// flags the last permitted cycle.
module run_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/counter_run_controller.sv
// Sequences one counting run of the counter datapath: clear, count until
// done or watchdog abort, then hold until software acknowledges.
module counter_run_controller
    import counter_run_controller_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int RUN_W   = RUN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ack,
    input  logic             done,
    output logic             en,
    output logic             clear,
    output logic             busy,
    output logic             ready,
    output logic             irq,
    output logic             timeout_err,
    output logic             overrun,
    output logic [RUN_W-1:0] run_count
);

    state_t           state_reg;
    state_t           state_next;
    logic             recover_reg;
    logic             irq_reg;
    logic             overrun_reg;
    logic [RUN_W-1:0] run_count_reg;
    logic             wd_load;
    logic             wd_inc;
    logic             wd_expired;

    run_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (wd_load),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start) state_next = ST_CLEAR;
            // A CLEAR entered from ERROR only scrubs the datapath, then idles.
            ST_CLEAR:    state_next = recover_reg ? ST_IDLE : ST_COUNT;
            ST_COUNT: begin
                if (done) begin
                    state_next = ST_WAIT_ACK;
                end else if (wd_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_WAIT_ACK: if (ack) state_next = ST_IDLE;
            ST_ERROR:    if (ack) state_next = ST_CLEAR;
            default:     state_next = ST_IDLE;
        endcase
    end

    assign wd_load = (state_reg == ST_CLEAR);
    assign wd_inc  = (state_reg == ST_COUNT) && !done && !wd_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            recover_reg   <= 1'b0;
            irq_reg       <= 1'b0;
            overrun_reg   <= 1'b0;
            run_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            recover_reg <= (state_reg == ST_ERROR) && ack;
            irq_reg     <= ((state_next == ST_WAIT_ACK) && (state_reg != ST_WAIT_ACK)) ||
                           ((state_next == ST_ERROR) && (state_reg != ST_ERROR));
            if (ack) begin
                overrun_reg <= 1'b0;
            end else if (start && (state_reg != ST_IDLE)) begin
                overrun_reg <= 1'b1;
            end
            if ((state_reg == ST_COUNT) && done && (run_count_reg != {RUN_W{1'b1}})) begin
                run_count_reg <= run_count_reg + 1'b1;
            end
        end
    end

    assign en          = (state_reg == ST_COUNT);
    assign clear       = (state_reg == ST_CLEAR);
    assign busy        = ((state_reg == ST_CLEAR) && !recover_reg) || (state_reg == ST_COUNT);
    assign ready       = (state_reg == ST_WAIT_ACK);
    assign timeout_err = (state_reg == ST_ERROR);
    assign irq         = irq_reg;
    assign overrun     = overrun_reg;
    assign run_count   = run_count_reg;

endmodule
